// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if -- CPU-side request/response bus of the SRAM controller.
//
// Signals:
//   REQ_VALID  CPU access request
//   REQ_READY  controller can accept a request this cycle
//   REQ_WR     1=write, 0=read
//   REQ_SIZE   00 byte, 01 halfword, 10 word, 11 illegal
//   REQ_SIGNED sign-extend sub-word reads
//   REQ_ADDR   byte address (MEM_AW+2 bits)
//   REQ_WDATA  right-aligned write data
//   RSP_VALID  one-cycle completion pulse
//   RSP_ERR    access rejected (qualified by RSP_VALID)
//   RSP_RDATA  aligned, extended read data (0 for writes and errors)
//
// Modports: master = CPU side, slave = controller side.
interface sram_ctrl_if #(
  parameter int MEM_AW = 12
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WR;
  logic [1:0]        REQ_SIZE;
  logic              REQ_SIGNED;
  logic [MEM_AW+1:0] REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic              RSP_ERR;
  logic [31:0]       RSP_RDATA;

  modport master (
    output REQ_VALID, REQ_WR, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA
  );

  modport slave (
    input  REQ_VALID, REQ_WR, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl -- single-outstanding CPU access controller for a 32-bit
// synchronous SRAM. Byte/halfword writes are done as read-modify-write so
// the SRAM always sees full-word accesses with all byte enables set.
//
// Ports:
//   CLK      clock, all state changes on posedge
//   RST      asynchronous active-high reset
//   bus      CPU request/response bus (sram_ctrl_if.slave)
//   M_CSN    SRAM chip select, active-low (registered)
//   M_WE     SRAM write enable, 1=write (registered)
//   M_BE     SRAM byte enables (registered)
//   M_ADDR   SRAM word address (registered)
//   M_WDATA  SRAM write data (registered)
//   M_RDATA  SRAM read data, valid the cycle after the sampling edge
module sram_ctrl #(
  parameter int MEM_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  sram_ctrl_if.slave        bus,
  output logic              M_CSN,
  output logic              M_WE,
  output logic [3:0]        M_BE,
  output logic [MEM_AW-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  input  logic [31:0]       M_RDATA
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAPT = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]  state;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  // Only the lane bits of the address are kept here; the word part lives
  // in M_ADDR, which holds its value for the whole access.
  logic [1:0]  lane_q;
  // Only the low half of the write data feeds the RMW merge; word writes
  // go straight from the bus into M_WDATA on the accept edge.
  logic [15:0] wdata_q;

  logic        req_misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] merged;

  assign bus.REQ_READY = (state == IDLE);

  // Size 11 is always rejected; otherwise the address must be naturally
  // aligned to the access size.
  always_comb begin
    req_misaligned = 1'b0;
    case (bus.REQ_SIZE)
      2'b01:   req_misaligned = bus.REQ_ADDR[0];
      2'b10:   req_misaligned = |bus.REQ_ADDR[1:0];
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Lane extraction / extension for reads, and lane replacement for RMW
  // writes, both working on the word the SRAM returns during CAPT.
  always_comb begin
    rd_byte = M_RDATA[7:0];
    case (lane_q)
      2'b01:   rd_byte = M_RDATA[15:8];
      2'b10:   rd_byte = M_RDATA[23:16];
      2'b11:   rd_byte = M_RDATA[31:24];
      default: rd_byte = M_RDATA[7:0];
    endcase
    rd_half = lane_q[1] ? M_RDATA[31:16] : M_RDATA[15:0];

    rd_ext = M_RDATA;
    case (size_q)
      2'b00:   rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: rd_ext = M_RDATA;
    endcase

    merged = M_RDATA;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        2'b11:   merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Main FSM. The SRAM-side outputs are loaded on the edge that enters
  // RD/WR so they are registered yet line up with the state; the response
  // outputs are loaded on the edge that enters RESP and cleared when
  // leaving it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      wr_q          <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      M_CSN         <= 1'b1;
      M_WE          <= 1'b0;
      M_BE          <= 4'h0;
      M_ADDR        <= '0;
      M_WDATA       <= 32'h0;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_ERR   <= 1'b0;
      bus.RSP_RDATA <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            wr_q     <= bus.REQ_WR;
            size_q   <= bus.REQ_SIZE;
            signed_q <= bus.REQ_SIGNED;
            lane_q   <= bus.REQ_ADDR[1:0];
            wdata_q  <= bus.REQ_WDATA[15:0];
            if (req_misaligned) begin
              bus.RSP_VALID <= 1'b1;
              bus.RSP_ERR   <= 1'b1;
              bus.RSP_RDATA <= 32'h0;
              state         <= RESP;
            end else begin
              M_CSN  <= 1'b0;
              M_BE   <= 4'hF;
              M_ADDR <= bus.REQ_ADDR[MEM_AW+1:2];
              if (bus.REQ_WR && bus.REQ_SIZE == 2'b10) begin
                M_WE    <= 1'b1;
                M_WDATA <= bus.REQ_WDATA;
                state   <= WR;
              end else begin
                // Reads and sub-word writes both start by reading the word.
                M_WE  <= 1'b0;
                state <= RD;
              end
            end
          end
        end
        RD: begin
          M_CSN <= 1'b1;
          M_WE  <= 1'b0;
          state <= CAPT;
        end
        CAPT: begin
          if (wr_q) begin
            M_CSN   <= 1'b0;
            M_WE    <= 1'b1;
            M_WDATA <= merged;
            state   <= WR;
          end else begin
            bus.RSP_VALID <= 1'b1;
            bus.RSP_ERR   <= 1'b0;
            bus.RSP_RDATA <= rd_ext;
            state         <= RESP;
          end
        end
        WR: begin
          M_CSN         <= 1'b1;
          M_WE          <= 1'b0;
          bus.RSP_VALID <= 1'b1;
          bus.RSP_ERR   <= 1'b0;
          bus.RSP_RDATA <= 32'h0;
          state         <= RESP;
        end
        RESP: begin
          bus.RSP_VALID <= 1'b0;
          bus.RSP_ERR   <= 1'b0;
          bus.RSP_RDATA <= 32'h0;
          state         <= IDLE;
        end
        default: begin
          M_CSN         <= 1'b1;
          M_WE          <= 1'b0;
          bus.RSP_VALID <= 1'b0;
          bus.RSP_ERR   <= 1'b0;
          bus.RSP_RDATA <= 32'h0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
